branch_resolve: RTL and testbench

Execute-stage branch resolution unit, the back end of the decode-stage static predictor (backward taken, forward not taken). It evaluates the real MIPS branch condition, compares it with the prediction carried down from ID, and on a mispredict issues a single PC redirect to fetch. The redirect is held until the delay-slot instruction has been fetched and fetch accepts it. It also keeps branch and mispredict performance counters.

---
 rtl/branch_resolve_pkg.sv | 20 ++
 rtl/branch_resolve_cond.sv | 34 +++
 rtl/branch_resolve.sv | 94 +++++++++
 tb/tb_branch_resolve.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the execute-stage branch resolver: MIPS branch
// opcodes, REGIMM rt codes and the redirect FSM state encodings.
package branch_resolve_pkg;

  localparam logic [5:0] EXE_BEQ     = 6'b000100;
  localparam logic [5:0] EXE_BNE     = 6'b000101;
  localparam logic [5:0] EXE_BLEZ    = 6'b000110;
  localparam logic [5:0] EXE_BGTZ    = 6'b000111;
  localparam logic [5:0] EXE_BRANCHS = 6'b000001;

  localparam logic [4:0] EXE_BLTZ    = 5'b00000;
  localparam logic [4:0] EXE_BGEZ    = 5'b00001;
  localparam logic [4:0] EXE_BLTZAL  = 5'b10000;
  localparam logic [4:0] EXE_BGEZAL  = 5'b10001;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_DS  = 2'd1;
  localparam logic [1:0] ST_ISSUE    = 2'd2;

endpackage

// File: rtl/branch_resolve_cond.sv
// Pure combinational MIPS branch condition evaluator, shared with the ID
// compare path.
module branch_cond
  import branch_resolve_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [4:0]  rt_code,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        take
);

  logic a_zero;
  assign a_zero = (a == 32'd0);

  always_comb begin
    take = 1'b0;
    case (opcode)
      EXE_BEQ:  take = (a == b);
      EXE_BNE:  take = (a != b);
      EXE_BLEZ: take = a[31] | a_zero;
      EXE_BGTZ: take = ~a[31] & ~a_zero;
      EXE_BRANCHS: begin
        case (rt_code)
          EXE_BLTZ, EXE_BLTZAL: take = a[31];
          EXE_BGEZ, EXE_BGEZAL: take = ~a[31];
          default:              take = 1'b0;
        endcase
      end
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: evaluates the branch, detects mispredicts
// against the static ID prediction and holds a single PC redirect for fetch.
//
// state      | meaning
// IDLE       | no redirect pending, branches may resolve
// WAIT_DS    | mispredict seen, waiting for the delay slot to reach ID
// ISSUE      | redirect_valid high until fetch accepts it
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              branchE,
  input  logic              pred_takeE,
  input  logic [31:0]       instrE,
  input  logic [31:0]       rs_valE,
  input  logic [31:0]       rt_valE,
  input  logic [31:0]       pc_plus4E,
  input  logic [31:0]       immE,
  input  logic              stallE,
  input  logic              flush_excE,
  input  logic              ds_readyD,
  input  logic              redirect_ready,
  output logic              actual_takeE,
  output logic              mispredE,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic              busy,
  output logic [PERF_W-1:0] branch_cnt,
  output logic [PERF_W-1:0] mispred_cnt
);

  logic [1:0]  state_q;
  logic        cond_take;
  logic        res;
  logic [31:0] target;
  logic        unused_fields;

  assign unused_fields = ^{instrE[25:21], instrE[15:0], immE[31:30]};

  branch_cond u_cond (
    .opcode  (instrE[31:26]),
    .rt_code (instrE[20:16]),
    .a       (rs_valE),
    .b       (rt_valE),
    .take    (cond_take)
  );

  assign actual_takeE = branchE & cond_take;
  assign res          = branchE & ~stallE & ~flush_excE & (state_q == ST_IDLE);
  assign mispredE     = res & (actual_takeE ^ pred_takeE);

  // Not-taken correction skips the delay slot, which is already in ID.
  assign target = actual_takeE ? (pc_plus4E + {immE[29:0], 2'b00})
                               : (pc_plus4E + 32'd4);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      redirect_pc <= 32'd0;
    end else if (flush_excE) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mispredE) begin
            redirect_pc <= target;
            state_q     <= ds_readyD ? ST_ISSUE : ST_WAIT_DS;
          end
        end
        ST_WAIT_DS: if (ds_readyD) state_q <= ST_ISSUE;
        ST_ISSUE:   if (redirect_ready) state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (res)      branch_cnt  <= branch_cnt + PERF_W'(1);
      if (mispredE) mispred_cnt <= mispred_cnt + PERF_W'(1);
    end
  end

  // Decoded straight from the state register so an async reset drops it at once.
  assign redirect_valid = (state_q == ST_ISSUE);
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve; a second instance with
// 2-bit counters exercises counter wrap-around on the same stimulus.
module tb_branch_resolve;

  logic        clk;
  logic        resetn;
  logic        branchE, pred_takeE, stallE, flush_excE, ds_readyD, redirect_ready;
  logic [31:0] instrE, rs_valE, rt_valE, pc_plus4E, immE;
  logic        actual_takeE, mispredE, redirect_valid, busy;
  logic [31:0] redirect_pc, branch_cnt, mispred_cnt;
  logic        actual_s, mispred_s, valid_s, busy_s;
  logic [31:0] pc_s;
  logic [1:0]  branch_cnt_s, mispred_cnt_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp;
  } cvec_t;
  cvec_t cv[17];

  branch_resolve dut (
    .clk(clk), .resetn(resetn), .branchE(branchE), .pred_takeE(pred_takeE),
    .instrE(instrE), .rs_valE(rs_valE), .rt_valE(rt_valE), .pc_plus4E(pc_plus4E),
    .immE(immE), .stallE(stallE), .flush_excE(flush_excE), .ds_readyD(ds_readyD),
    .redirect_ready(redirect_ready), .actual_takeE(actual_takeE), .mispredE(mispredE),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_resolve #(.PERF_W(2)) dut_small (
    .clk(clk), .resetn(resetn), .branchE(branchE), .pred_takeE(pred_takeE),
    .instrE(instrE), .rs_valE(rs_valE), .rt_valE(rt_valE), .pc_plus4E(pc_plus4E),
    .immE(immE), .stallE(stallE), .flush_excE(flush_excE), .ds_readyD(ds_readyD),
    .redirect_ready(redirect_ready), .actual_takeE(actual_s), .mispredE(mispred_s),
    .redirect_valid(valid_s), .redirect_pc(pc_s), .busy(busy_s),
    .branch_cnt(branch_cnt_s), .mispred_cnt(mispred_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt);
    return {op, 5'd3, rt, 16'h1234};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_br(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                          input logic pred, input logic [31:0] pc4, input logic [31:0] imm);
    branchE    = 1'b1;
    instrE     = ins;
    rs_valE    = a;
    rt_valE    = b;
    pred_takeE = pred;
    pc_plus4E  = pc4;
    immE       = imm;
  endtask

  task automatic test_reset();
    resetn = 1'b0; branchE = 0; pred_takeE = 0; stallE = 0; flush_excE = 0;
    ds_readyD = 0; redirect_ready = 0; instrE = 0; rs_valE = 0; rt_valE = 0;
    pc_plus4E = 0; immE = 0;
    #3;
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b exp 0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", redirect_pc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b exp 0", busy); end
    checks++; if (branch_cnt !== 32'h0 || mispred_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d exp 0/0", branch_cnt, mispred_cnt); end
    @(posedge clk); #1;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_beq_mispredict();
    drive_br(mk(6'b000100, 5'd0), 32'd5, 32'd5, 1'b0, 32'h100, 32'hFFFFFFFC);
    ds_readyD = 1'b1;
    #1;
    checks++; if (actual_takeE !== 1'b1) begin errors++; $display("FAIL beq_actual: got %0b exp 1", actual_takeE); end
    checks++; if (mispredE !== 1'b1) begin errors++; $display("FAIL beq_mispred: got %0b exp 1", mispredE); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL beq_valid_early: got %0b exp 0", redirect_valid); end
    tick();
    branchE = 1'b0; ds_readyD = 1'b0;
    #1;
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL beq_valid: got %0b exp 1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h000000F0) begin errors++; $display("FAIL beq_pc: got %h exp 000000f0", redirect_pc); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL beq_busy: got %0b exp 1", busy); end
    checks++; if (branch_cnt !== 32'd1 || mispred_cnt !== 32'd1) begin errors++; $display("FAIL beq_cnt: got %0d/%0d exp 1/1", branch_cnt, mispred_cnt); end
    checks++; if (branch_cnt_s !== 2'd1 || mispred_cnt_s !== 2'd1) begin errors++; $display("FAIL beq_cnt_small: got %0d/%0d exp 1/1", branch_cnt_s, mispred_cnt_s); end
    redirect_ready = 1'b1;
    #1;
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL beq_valid_accept: got %0b exp 1", redirect_valid); end
    tick();
    redirect_ready = 1'b0;
    #1;
    checks++; if (redirect_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL beq_drop: got valid %0b busy %0b exp 0 0", redirect_valid, busy); end
  endtask

  task automatic test_cond_table();
    cv[0]  = '{mk(6'b000100, 5'd0),  32'd3,         32'd3, 1'b1};
    cv[1]  = '{mk(6'b000100, 5'd0),  32'd3,         32'd4, 1'b0};
    cv[2]  = '{mk(6'b000101, 5'd0),  32'd3,         32'd4, 1'b1};
    cv[3]  = '{mk(6'b000101, 5'd0),  32'd9,         32'd9, 1'b0};
    cv[4]  = '{mk(6'b000110, 5'd0),  32'd0,         32'd0, 1'b1};
    cv[5]  = '{mk(6'b000110, 5'd0),  32'd1,         32'd0, 1'b0};
    cv[6]  = '{mk(6'b000110, 5'd0),  32'h80000000,  32'd0, 1'b1};
    cv[7]  = '{mk(6'b000111, 5'd0),  32'd1,         32'd0, 1'b1};
    cv[8]  = '{mk(6'b000111, 5'd0),  32'd0,         32'd0, 1'b0};
    cv[9]  = '{mk(6'b000001, 5'd0),  32'hFFFFFFFF,  32'd0, 1'b1};
    cv[10] = '{mk(6'b000001, 5'd0),  32'd0,         32'd0, 1'b0};
    cv[11] = '{mk(6'b000001, 5'd1),  32'd0,         32'd0, 1'b1};
    cv[12] = '{mk(6'b000001, 5'd1),  32'h80000000,  32'd0, 1'b0};
    cv[13] = '{mk(6'b000001, 5'd16), 32'h80000000,  32'd0, 1'b1};
    cv[14] = '{mk(6'b000001, 5'd17), 32'h7FFFFFFF,  32'd0, 1'b1};
    cv[15] = '{mk(6'b000001, 5'd2),  32'h80000000,  32'd0, 1'b0};
    cv[16] = '{mk(6'b000000, 5'd0),  32'd5,         32'd5, 1'b0};
    stallE = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive_br(cv[i].instr, cv[i].a, cv[i].b, ~cv[i].exp, 32'h100, 32'h4);
      #1;
      checks++; if (actual_takeE !== cv[i].exp) begin errors++; $display("FAIL cond_%0d: got %0b exp %0b", i, actual_takeE, cv[i].exp); end
      checks++; if (mispredE !== 1'b0) begin errors++; $display("FAIL cond_stall_%0d: mispred got %0b exp 0", i, mispredE); end
      tick();
    end
    stallE = 1'b0;
    drive_br(mk(6'b000100, 5'd0), 32'd7, 32'd7, 1'b0, 32'h100, 32'h4);
    branchE = 1'b0;
    #1;
    checks++; if (actual_takeE !== 1'b0) begin errors++; $display("FAIL cond_nobranch: got %0b exp 0", actual_takeE); end
    tick();
    checks++; if (branch_cnt !== 32'd1 || busy !== 1'b0) begin errors++; $display("FAIL cond_nocount: got cnt %0d busy %0b exp 1 0", branch_cnt, busy); end
  endtask

  task automatic test_bne_correct();
    drive_br(mk(6'b000101, 5'd0), 32'd8, 32'd8, 1'b0, 32'h180, 32'h10);
    ds_readyD = 1'b1;
    #1;
    checks++; if (mispredE !== 1'b0) begin errors++; $display("FAIL bne_mispred: got %0b exp 0", mispredE); end
    tick();
    branchE = 1'b0; ds_readyD = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL bne_idle: got busy %0b valid %0b exp 0 0", busy, redirect_valid); end
    checks++; if (branch_cnt !== 32'd2 || mispred_cnt !== 32'd1) begin errors++; $display("FAIL bne_cnt: got %0d/%0d exp 2/1", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_bgtz_not_taken();
    drive_br(mk(6'b000111, 5'd0), 32'hFFFFFFFF, 32'd0, 1'b1, 32'h200, 32'h40);
    ds_readyD = 1'b1;
    #1;
    checks++; if (actual_takeE !== 1'b0 || mispredE !== 1'b1) begin errors++; $display("FAIL bgtz_resolve: got take %0b mispred %0b exp 0 1", actual_takeE, mispredE); end
    tick();
    branchE = 1'b0; ds_readyD = 1'b0;
    #1;
    checks++; if (redirect_pc !== 32'h204 || redirect_valid !== 1'b1) begin errors++; $display("FAIL bgtz_pc: got %h valid %0b exp 00000204 1", redirect_pc, redirect_valid); end
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    #1;
    checks++; if (branch_cnt !== 32'd3 || mispred_cnt !== 32'd2) begin errors++; $display("FAIL bgtz_cnt: got %0d/%0d exp 3/2", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_wait_ds();
    drive_br(mk(6'b000100, 5'd0), 32'd1, 32'd2, 1'b1, 32'h300, 32'h40);
    ds_readyD = 1'b0;
    #1;
    checks++; if (mispredE !== 1'b1) begin errors++; $display("FAIL wds_mispred: got %0b exp 1", mispredE); end
    tick();
    branchE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (busy !== 1'b1 || redirect_valid !== 1'b0) begin errors++; $display("FAIL wds_wait_%0d: got busy %0b valid %0b exp 1 0", i, busy, redirect_valid); end
      tick();
    end
    drive_br(mk(6'b000100, 5'd0), 32'd7, 32'd7, 1'b0, 32'h900, 32'h40);
    #1;
    checks++; if (mispredE !== 1'b0) begin errors++; $display("FAIL wds_violation: mispred got %0b exp 0", mispredE); end
    tick();
    branchE = 1'b0;
    #1;
    checks++; if (branch_cnt !== 32'd4 || mispred_cnt !== 32'd3) begin errors++; $display("FAIL wds_cnt: got %0d/%0d exp 4/3", branch_cnt, mispred_cnt); end
    checks++; if (busy !== 1'b1 || redirect_valid !== 1'b0) begin errors++; $display("FAIL wds_still: got busy %0b valid %0b exp 1 0", busy, redirect_valid); end
    ds_readyD = 1'b1;
    tick();
    ds_readyD = 1'b0;
    #1;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h304) begin errors++; $display("FAIL wds_issue: got valid %0b pc %h exp 1 00000304", redirect_valid, redirect_pc); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h304) begin errors++; $display("FAIL wds_hold_%0d: got valid %0b pc %h exp 1 00000304", i, redirect_valid, redirect_pc); end
    end
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    #1;
    checks++; if (redirect_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wds_accept: got valid %0b busy %0b exp 0 0", redirect_valid, busy); end
  endtask

  task automatic test_flush();
    drive_br(mk(6'b000101, 5'd0), 32'd1, 32'd1, 1'b1, 32'h400, 32'h40);
    ds_readyD = 1'b0;
    tick();
    branchE = 1'b0;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_wds_busy: got %0b exp 1", busy); end
    ds_readyD = 1'b1; flush_excE = 1'b1;
    tick();
    ds_readyD = 1'b0; flush_excE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (busy !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL flush_wds_%0d: got busy %0b valid %0b exp 0 0", i, busy, redirect_valid); end
      tick();
    end
    drive_br(mk(6'b000100, 5'd0), 32'd9, 32'd9, 1'b0, 32'h480, 32'h40);
    flush_excE = 1'b1;
    #1;
    checks++; if (mispredE !== 1'b0) begin errors++; $display("FAIL flush_res: mispred got %0b exp 0", mispredE); end
    tick();
    branchE = 1'b0; flush_excE = 1'b0;
    checks++; if (branch_cnt !== 32'd5 || busy !== 1'b0) begin errors++; $display("FAIL flush_res_cnt: got cnt %0d busy %0b exp 5 0", branch_cnt, busy); end
    drive_br(mk(6'b000110, 5'd0), 32'd0, 32'd0, 1'b0, 32'h500, 32'h8);
    ds_readyD = 1'b1;
    tick();
    branchE = 1'b0; ds_readyD = 1'b0;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h520) begin errors++; $display("FAIL flush_issue_pc: got valid %0b pc %h exp 1 00000520", redirect_valid, redirect_pc); end
    flush_excE = 1'b1;
    tick();
    flush_excE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (busy !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL flush_issue_%0d: got busy %0b valid %0b exp 0 0", i, busy, redirect_valid); end
      tick();
    end
    checks++; if (branch_cnt !== 32'd6 || mispred_cnt !== 32'd5) begin errors++; $display("FAIL flush_cnt: got %0d/%0d exp 6/5", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_wrap_and_reset();
    for (int i = 0; i < 2; i++) begin
      drive_br(mk(6'b000001, 5'd1), 32'd0, 32'd0, 1'b0, 32'h600, 32'h1);
      ds_readyD = 1'b1;
      tick();
      branchE = 1'b0; ds_readyD = 1'b0; redirect_ready = 1'b1;
      tick();
      redirect_ready = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      drive_br(mk(6'b000100, 5'd0), 32'd1, 32'd2, 1'b0, 32'h700, 32'h1);
      tick();
    end
    branchE = 1'b0;
    checks++; if (branch_cnt !== 32'd11 || mispred_cnt !== 32'd7) begin errors++; $display("FAIL wrap_pre: got %0d/%0d exp 11/7", branch_cnt, mispred_cnt); end
    checks++; if (branch_cnt_s !== 2'd3 || mispred_cnt_s !== 2'd3) begin errors++; $display("FAIL wrap_pre_small: got %0d/%0d exp 3/3", branch_cnt_s, mispred_cnt_s); end
    drive_br(mk(6'b000001, 5'd0), 32'h80000000, 32'd0, 1'b0, 32'h800, 32'h2);
    ds_readyD = 1'b1;
    tick();
    branchE = 1'b0; ds_readyD = 1'b0;
    checks++; if (branch_cnt_s !== 2'd0 || mispred_cnt_s !== 2'd0) begin errors++; $display("FAIL wrap_small: got %0d/%0d exp 0/0", branch_cnt_s, mispred_cnt_s); end
    checks++; if (branch_cnt !== 32'd12 || mispred_cnt !== 32'd8) begin errors++; $display("FAIL wrap_wide: got %0d/%0d exp 12/8", branch_cnt, mispred_cnt); end
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h808) begin errors++; $display("FAIL wrap_issue: got valid %0b pc %h exp 1 00000808", redirect_valid, redirect_pc); end
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (redirect_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL areset_valid: got valid %0b busy %0b exp 0 0", redirect_valid, busy); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL areset_pc: got %h exp 0", redirect_pc); end
    checks++; if (branch_cnt !== 32'h0 || mispred_cnt !== 32'h0) begin errors++; $display("FAIL areset_cnt: got %0d/%0d exp 0/0", branch_cnt, mispred_cnt); end
    tick();
    resetn = 1'b1;
    tick();
    checks++; if (redirect_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL areset_after: got valid %0b busy %0b exp 0 0", redirect_valid, busy); end
  endtask

  initial begin
    test_reset();
    test_beq_mispredict();
    test_cond_table();
    test_bne_correct();
    test_bgtz_not_taken();
    test_wait_ds();
    test_flush();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
